mul_result_unit: RTL

- Pipelined multiply execution unit that issues operands to the existing combinational multiplier64 (128-bit signed product) and consumes its product.
- Registers the product and applies sign corrections for unsigned and mixed-sign ops.
- Selects the low or high 64-bit half per op and delivers a tagged result to writeback over a valid/ready handshake.
- Sits between the decode/issue stage and the register-file writeback mux; throughput is one op per clock.

---
 rtl/mul_pkg.sv | 12 +
 rtl/multiplier64.sv | 18 +
 rtl/mul_result_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the multiply result unit: data widths and op encodings.
package mul_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned PROD_W = 2 * XLEN;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

endpackage

// File: rtl/multiplier64.sv
// Combinational 64x64 signed multiplier producing the full 128-bit product.
module multiplier64
    import mul_pkg::*;
(
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [PROD_W-1:0] prod
);

    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] b_ext;

    // Sign-extend to full width; the truncated unsigned product equals the signed product.
    assign a_ext = {{XLEN{a[XLEN-1]}}, a};
    assign b_ext = {{XLEN{b[XLEN-1]}}, b};
    assign prod  = a_ext * b_ext;

endmodule

// File: rtl/mul_result_unit.sv
// Three-stage multiply unit: operand register, product register with sign
// correction, and a tagged output register behind a valid/ready handshake.
module mul_result_unit
    import mul_pkg::*;
#(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0]   a0, b0;
    logic [1:0]        op0;
    logic [TAG_W-1:0]  tag0;
    logic              v0;

    logic [PROD_W-1:0] p1;
    logic [XLEN-1:0]   a1, b1;
    logic [1:0]        op1;
    logic [TAG_W-1:0]  tag1;
    logic              v1;

    logic [PROD_W-1:0] prod;
    logic              r0, r1, r2;
    logic [XLEN-1:0]   corr_su, corr_uu, sel_result;

    // Ready chain: a stage may load when it is empty or its successor advances.
    assign r2       = !out_valid || out_ready;
    assign r1       = !v1 || r2;
    assign r0       = !v0 || r1;
    assign in_ready = r0;

    multiplier64 u_mul (
        .a    (a0),
        .b    (b0),
        .prod (prod)
    );

    // Signed-product fixups that turn the high half into MULHSU/MULHU results.
    assign corr_su = b1[XLEN-1] ? a1 : '0;
    assign corr_uu = corr_su + (a1[XLEN-1] ? b1 : '0);

    always_comb begin
        sel_result = p1[XLEN-1:0];
        case (op1)
            MUL_OP_MUL:    sel_result = p1[XLEN-1:0];
            MUL_OP_MULH:   sel_result = p1[PROD_W-1:XLEN];
            MUL_OP_MULHSU: sel_result = p1[PROD_W-1:XLEN] + corr_su;
            MUL_OP_MULHU:  sel_result = p1[PROD_W-1:XLEN] + corr_uu;
            default:       sel_result = p1[XLEN-1:0];
        endcase
    end

    // Data only loads alongside a valid so idle operands never reach the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            v0   <= 1'b0;
            a0   <= '0;
            b0   <= '0;
            op0  <= '0;
            tag0 <= '0;
        end else if (r0) begin
            v0 <= in_valid;
            if (in_valid) begin
                a0   <= in_a;
                b0   <= in_b;
                op0  <= in_op;
                tag0 <= in_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            p1   <= '0;
            a1   <= '0;
            b1   <= '0;
            op1  <= '0;
            tag1 <= '0;
        end else if (r1) begin
            v1 <= v0;
            if (v0) begin
                p1   <= prod;
                a1   <= a0;
                b1   <= b0;
                op1  <= op0;
                tag1 <= tag0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (r2) begin
            out_valid <= v1;
            if (v1) begin
                out_result <= sel_result;
                out_tag    <= tag1;
            end
        end
    end

endmodule
